ibex_compressed_encoder: RTL
============================

Name: ibex_compressed_encoder

Overview:
- Streaming RV32 instruction compressor; the inverse of the core's RVC expansion path.
- Accepts 32-bit instructions. Re-encodes each one to its 16-bit RVC form when an exact equivalent exists, otherwise passes it through unchanged.
- Packs the resulting 16/32-bit parcels little-endian into 32-bit words for instruction-memory image builders and the test/debug code loader.
- Encodes one instruction at a time and copies offsets literally; it does no address relocation.

Parameters:
- NOP16, 16'h0001, C.NOP halfword used to pad a trailing half-word on flush.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- compress_en_i  in  1  1: compress where legal; 0: force 32-bit pass-through
- in_valid_i  in  1  input instruction valid
- in_ready_o  out  1  input can be accepted this cycle
- in_instr_i  in  32  uncompressed instruction (bits[1:0]==2'b11 expected)
- in_last_i  in  1  last instruction of stream; flush after it
- out_valid_o  out  1  packed word valid
- out_ready_i  in  1  downstream accepts word
- out_word_o  out  32  packed word; lower halfword is the earlier parcel
- out_last_o  out  1  final word of stream

Behaviour:
- Interface rules:
  - Clock is clk_i; reset is rst_i, synchronous, active-high.
  - Accept occurs when in_valid_i && in_ready_o.
  - in_ready_o = (state==RUN) && (!out_valid_o || out_ready_i); combinational on out_ready_i.
- Reset: out_valid_o=0, out_word_o=0, out_last_o=0, hold_v=0, hold=0, state=RUN. Any pending half or flush in progress is discarded.
- Compression (combinational, only when compress_en_i=1; first match wins):
  - addi x0,x0,0 -> 16'h0001.
  - C.ADDI: addi, rd==rs1!=0, imm in [-32,31], imm!=0.
  - C.LI: addi, rs1==0, rd!=0, imm in [-32,31].
  - C.MV: add, rs1==0, rd!=0, rs2!=0.
  - C.ADD: add, rd==rs1!=0, rs2!=0.
  - C.SUB/XOR/OR/AND: rd==rs1 and rs2 both in x8..x15.
  - C.LW/C.SW: rd/rs1 (rs2/rs1 for store) in x8..x15, imm[1:0]==0, 0<=imm<=124.
  - C.JR: jalr, rd==0, imm==0, rs1!=0.
  - C.JALR: jalr, rd==1, imm==0, rs1!=0.
  - C.EBREAK: 32'h00100073 -> 16'h9002.
  - Anything else, including illegal encodings or bits[1:0]!=2'b11, passes through as 32 bits.
- Packing on accept, by hold_v and parcel size:
  - hold_v=0, 16-bit parcel c:
    - not last: hold<=c, hold_v<=1, no output.
    - last: emit {NOP16,c} with out_last=1.
  - hold_v=0, 32-bit: emit instr with out_last=in_last_i.
  - hold_v=1, 16-bit: emit {c,hold}, hold_v<=0, out_last=in_last_i.
  - hold_v=1, 32-bit: emit {instr[15:0],hold}, hold<=instr[31:16], hold_v stays 1.
    - If in_last_i: out_last=0 and state<=FLUSH.
- FLUSH state:
  - in_ready_o=0.
  - When the output slot is free, emit {NOP16,hold} with out_last=1, then hold_v<=0 and state<=RUN.
- Output register:
  - Loads one cycle after accept (latency 1).
  - Holds stable while out_valid_o && !out_ready_i.
  - Drops valid on out_ready_i when nothing new is loaded.
  - Accepting a word and loading a new one in the same cycle is legal.
- compress_en_i is sampled on accept. Toggling it mid-stream is legal; the pending half is kept.

Optional Feature:
- Macro: IBEX_COMPRESSOR_STATS_EN.
- When defined:
  - Adds outputs stat_total_o[31:0] and stat_comp_o[31:0].
  - They count accepted instructions and accepted instructions emitted as 16-bit.
  - Both are cleared by rst_i and saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Two accepts of addi x5,x5,1 (0x00128293), last on second -> single word 0x02850285, out_last_o=1.
2. Single ebreak 0x00100073 with in_last_i=1 -> 0x00019002, out_last_o=1.
3. lw x8,4(x9) (0x0044A403), then lui x5,1 (0x000012B7) with in_last_i=1:
   - first word 0x12B740C0, out_last_o=0;
   - then 0x00010000, out_last_o=1;
   - in_ready_o=0 during FLUSH.
4. compress_en_i=0, addi x5,x5,1 with in_last_i=1 -> 0x00128293 unchanged.
5. out_ready_i=0 for 3 cycles with out_valid_o=1 -> in_ready_o=0, out_word_o stable; resumes on out_ready_i=1 with no lost or duplicated word.
6. rst_i asserted while in FLUSH -> next cycle out_valid_o=0, in_ready_o=1, no padded word emitted.

Source files
------------

// File: rtl/ibex_compressed_encoder.sv
// ibex_compressed_encoder: RV32 to RVC re-encoder packing parcels into 32-bit words; IBEX_COMPRESSOR_STATS_EN adds stat counters
module ibex_compressed_encoder #(
    parameter logic [15:0] NOP16 = 16'h0001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        compress_en_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic        in_last_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_word_o,
    output logic        out_last_o
`ifdef IBEX_COMPRESSOR_STATS_EN
    ,
    output logic [31:0] stat_total_o,
    output logic [31:0] stat_comp_o
`endif
);
    typedef enum logic {RUN, FLUSH} state_e;
    state_e state_q, state_d;
    logic hold_v_q, hold_v_d, is16, load, last_d, accept, slot_free, imm_small;
    logic is_addi, is_add, is_alu, is_lw, is_sw, is_jalr;
    logic [15:0] hold_q, hold_d, c16;
    logic [31:0] word_d;
    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [11:0] imm_i;
    assign op = in_instr_i[6:0];
    assign rd = in_instr_i[11:7];
    assign f3 = in_instr_i[14:12];
    assign rs1 = in_instr_i[19:15];
    assign rs2 = in_instr_i[24:20];
    assign f7 = in_instr_i[31:25];
    assign imm_i = in_instr_i[31:20];
    assign imm_small = &imm_i[11:5] || ~|imm_i[11:5];
    assign is_addi = op == 7'b0010011 && f3 == 3'b000;
    assign is_add = op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0;
    assign is_alu = op == 7'b0110011 && ((f7 == 7'b0100000 && f3 == 3'b000) ||
                    (f7 == 7'b0 && (f3 == 3'b100 || f3[2:1] == 2'b11)));
    assign is_lw = op == 7'b0000011 && f3 == 3'b010;
    assign is_sw = op == 7'b0100011 && f3 == 3'b010;
    assign is_jalr = op == 7'b1100111 && f3 == 3'b000;
    assign slot_free = !out_valid_o || out_ready_i;
    assign in_ready_o = state_q == RUN && slot_free;
    assign accept = in_valid_i && in_ready_o;
    always_comb begin
        c16 = '0;
        is16 = 1'b0;
        if (compress_en_i) begin
            is16 = 1'b1;
            if (in_instr_i == 32'h0000_0013)
                c16 = 16'h0001;
            else if (is_addi && rd == rs1 && rd != 5'd0 && imm_small && imm_i != 12'd0)
                c16 = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            else if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm_small)
                c16 = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
                c16 = {4'b1000, rd, rs2, 2'b10};
            else if (is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
                c16 = {4'b1001, rd, rs2, 2'b10};
            else if (is_alu && rd == rs1 && rd[4:3] == 2'b01 && rs2[4:3] == 2'b01)
                c16 = {6'b100011, rd[2:0], (f3 == 3'b100) ? 2'b01 : f3[1:0], rs2[2:0], 2'b01};
            else if (is_lw && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00)
                c16 = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
            else if (is_sw && rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01 && f7[6:2] == 5'd0 && rd[1:0] == 2'b00)
                c16 = {3'b110, f7[0], rd[4:3], rs1[2:0], rd[2], f7[1], rs2[2:0], 2'b00};
            else if (is_jalr && rd == 5'd0 && imm_i == 12'd0 && rs1 != 5'd0)
                c16 = {4'b1000, rs1, 5'd0, 2'b10};
            else if (is_jalr && rd == 5'd1 && imm_i == 12'd0 && rs1 != 5'd0)
                c16 = {4'b1001, rs1, 5'd0, 2'b10};
            else if (in_instr_i == 32'h0010_0073)
                c16 = 16'h9002;
            else
                is16 = 1'b0;
        end
    end
    // A 32-bit instruction straddles words when a half is pending; its top half becomes the new hold.
    always_comb begin
        state_d = state_q;
        hold_d = hold_q;
        hold_v_d = hold_v_q;
        load = 1'b0;
        word_d = out_word_o;
        last_d = out_last_o;
        if (state_q == FLUSH) begin
            if (slot_free) begin
                load = 1'b1;
                word_d = {NOP16, hold_q};
                last_d = 1'b1;
                hold_v_d = 1'b0;
                state_d = RUN;
            end
        end else if (accept) begin
            if (!hold_v_q && is16) begin
                load = in_last_i;
                word_d = {NOP16, c16};
                last_d = 1'b1;
                hold_d = in_last_i ? hold_q : c16;
                hold_v_d = !in_last_i;
            end else if (!hold_v_q) begin
                load = 1'b1;
                word_d = in_instr_i;
                last_d = in_last_i;
            end else if (is16) begin
                load = 1'b1;
                word_d = {c16, hold_q};
                last_d = in_last_i;
                hold_v_d = 1'b0;
            end else begin
                load = 1'b1;
                word_d = {in_instr_i[15:0], hold_q};
                last_d = 1'b0;
                hold_d = in_instr_i[31:16];
                state_d = in_last_i ? FLUSH : RUN;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            hold_q <= '0;
            hold_v_q <= 1'b0;
            out_valid_o <= 1'b0;
            out_word_o <= '0;
            out_last_o <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            hold_v_q <= hold_v_d;
            if (load) begin
                out_valid_o <= 1'b1;
                out_word_o <= word_d;
                out_last_o <= last_d;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end
`ifdef IBEX_COMPRESSOR_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_total_o <= '0;
            stat_comp_o <= '0;
        end else if (accept) begin
            stat_total_o <= stat_total_o + {31'd0, ~&stat_total_o};
            stat_comp_o <= stat_comp_o + {31'd0, is16 && ~&stat_comp_o};
        end
    end
`endif
endmodule
